// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the data-memory port between the CPU and a host port.
// Define DRAM_ARB_FAIRNESS_EN to bound host bursts to MAX_BURST with a forced CPU slot.
module dram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ext_en_l,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_mw,
  output logic [DATA_W-1:0] cpu_din,
  output logic              cpu_en_l,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_mw,
  input  logic [DATA_W-1:0] mem_q
);
  typedef enum logic [1:0] {S_CPU, S_HOST, S_YIELD} state_t;
  state_t state;
  logic   host_sel;
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("MAX_BURST out of range");
  end
  // Reset overrides ownership so nothing commits and the CPU stays stalled.
  assign host_sel   = (state == S_HOST) && !RESET;
  assign host_grant = host_sel;
  assign host_ack   = host_sel & host_req;
  assign cpu_en_l   = RESET | host_sel | ext_en_l;
  assign mem_addr   = host_sel ? host_addr : cpu_addr;
  assign mem_data   = host_sel ? host_wdata : cpu_data;
  assign mem_mw     = RESET ? 1'b0 : host_sel ? host_we & host_req : cpu_mw & ~ext_en_l;
  assign cpu_din    = mem_q;
  assign host_rdata = mem_q;
`ifdef DRAM_ARB_FAIRNESS_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST = BW'(MAX_BURST - 1);
  logic [BW-1:0] bcnt;
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_CPU;
    else if (state == S_HOST) state <= !host_req ? S_CPU : (bcnt == LAST) ? S_YIELD : S_HOST;
    else state <= host_req ? S_HOST : S_CPU;
    bcnt <= (RESET || state != S_HOST || !host_req || bcnt == LAST) ? '0 : bcnt + 1'b1;
  end
`else
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_CPU;
    else state <= host_req ? S_HOST : S_CPU;
  end
`endif
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed checks of the arbiter against a behavioural memory.
module tb_dram_arbiter;
  logic       CLK = 0, RESET = 1, ext_en_l = 0, cpu_mw = 0;
  logic       host_req = 0, host_we = 0;
  logic [7:0] cpu_addr = 0, cpu_data = 0, host_addr = 0, host_wdata = 0;
  logic [7:0] cpu_din, host_rdata, mem_addr, mem_data, mem_q;
  logic       cpu_en_l, host_ack, host_grant, mem_mw;
  logic [7:0] mem [256];
  int checks = 0, passes = 0;

  dram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
    .CLK(CLK), .RESET(RESET), .ext_en_l(ext_en_l), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_mw(cpu_mw), .cpu_din(cpu_din), .cpu_en_l(cpu_en_l), .host_req(host_req),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .host_grant(host_grant), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_mw(mem_mw), .mem_q(mem_q)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) if (mem_mw) mem[mem_addr] <= mem_data;
  assign mem_q = mem[mem_addr];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_req = 1; host_we = 1; host_addr = a; host_wdata = d;
    tick; tick;
    host_req = 0;
    tick;
  endtask

  task automatic test_reset;
    RESET = 1; host_req = 1; host_we = 1; cpu_mw = 1; cpu_addr = 8'h01; cpu_data = 8'h11;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++; if (mem_mw !== 1'b0) $display("FAIL reset_mw got %b want 0", mem_mw); else passes++;
      checks++; if (host_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", host_ack); else passes++;
      checks++; if (cpu_en_l !== 1'b1) $display("FAIL reset_en_l got %b want 1", cpu_en_l); else passes++;
      checks++; if (host_grant !== 1'b0) $display("FAIL reset_grant got %b want 0", host_grant); else passes++;
    end
    RESET = 0; cpu_mw = 0; host_addr = 8'h00; host_wdata = 8'h00;
    #1;
    checks++; if (host_ack !== 1'b0) $display("FAIL post_reset_ack got %b want 0", host_ack); else passes++;
    checks++; if (cpu_en_l !== 1'b0) $display("FAIL post_reset_en_l got %b want 0", cpu_en_l); else passes++;
    tick;
    checks++; if (host_ack !== 1'b1) $display("FAIL post_reset_ack_rise got %b want 1", host_ack); else passes++;
    tick;
    host_req = 0;
    tick;
  endtask

  task automatic test_single_write;
    host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 8'hA5;
    #1;
    checks++; if (host_ack !== 1'b0) $display("FAIL sw_req_cycle_ack got %b want 0", host_ack); else passes++;
    tick;
    checks++; if (host_ack !== 1'b1) $display("FAIL sw_ack got %b want 1", host_ack); else passes++;
    checks++; if (mem_addr !== 8'h20) $display("FAIL sw_addr got %h want 20", mem_addr); else passes++;
    checks++; if (mem_mw !== 1'b1) $display("FAIL sw_mw got %b want 1", mem_mw); else passes++;
    checks++; if (cpu_en_l !== 1'b1) $display("FAIL sw_en_l got %b want 1", cpu_en_l); else passes++;
    tick;
    host_req = 0;
    #1;
    checks++; if (mem[8'h20] !== 8'hA5) $display("FAIL sw_mem got %h want a5", mem[8'h20]); else passes++;
    checks++; if (host_ack !== 1'b0 || host_grant !== 1'b1) $display("FAIL sw_drop ack/grant got %b%b want 01", host_ack, host_grant); else passes++;
    tick;
    checks++; if (cpu_en_l !== 1'b0 || host_grant !== 1'b0) $display("FAIL sw_resume en_l/grant got %b%b want 00", cpu_en_l, host_grant); else passes++;
  endtask

  task automatic test_read;
    host_write(8'h21, 8'h3C);
    host_req = 1; host_we = 0; host_addr = 8'h21;
    tick;
    checks++; if (host_ack !== 1'b1) $display("FAIL rd_ack got %b want 1", host_ack); else passes++;
    checks++; if (host_rdata !== 8'h3C) $display("FAIL rd_data got %h want 3c", host_rdata); else passes++;
    checks++; if (cpu_din !== 8'h3C) $display("FAIL rd_cpu_din got %h want 3c", cpu_din); else passes++;
    checks++; if (mem_mw !== 1'b0) $display("FAIL rd_mw got %b want 0", mem_mw); else passes++;
    tick;
    host_req = 0;
    tick;
  endtask

  task automatic test_burst;
    logic [15:0] vec, want_vec;
    int idx, first, want_first, bad;
    logic a, e;
`ifdef DRAM_ARB_FAIRNESS_EN
    want_vec = 16'h0F7B; want_first = 5;
`else
    want_vec = 16'h0FFC; want_first = 12;
`endif
    idx = 0; vec = 0; first = -1;
    host_req = 1; host_we = 1; host_addr = 8'h80; host_wdata = 8'h10; cpu_mw = 0;
    tick;
    cpu_mw = 1; cpu_addr = 8'h40; cpu_data = 8'h77;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (first < 0 && mem[8'h40] === 8'h77) first = i;
      a = host_ack; e = cpu_en_l;
      vec = {vec[14:0], a};
      tick;
      if (a) begin
        idx++;
        if (idx == 10) host_req = 0;
        else begin host_addr = 8'h80 + 8'(idx); host_wdata = 8'h10 + 8'(idx); end
      end
      if (!e) cpu_mw = 0;
    end
    #1;
    if (first < 0 && mem[8'h40] === 8'h77) first = 12;
    checks++; if (vec !== want_vec) $display("FAIL burst_ack_pattern got %h want %h", vec, want_vec); else passes++;
    checks++; if (first != want_first) $display("FAIL burst_cpu_commit_cycle got %0d want %0d", first, want_first); else passes++;
    bad = 0;
    for (int i = 0; i < 10; i++) if (mem[8'h80 + 8'(i)] !== 8'h10 + 8'(i)) bad++;
    checks++; if (bad != 0) $display("FAIL burst_mem_contents got %0d bad want 0", bad); else passes++;
    cpu_mw = 0;
    tick;
    tick;
  endtask

  task automatic test_reset_mid_burst;
    host_write(8'h92, 8'hEE);
    host_req = 1; host_we = 1; host_addr = 8'h90; host_wdata = 8'h50;
    tick;
    tick; host_addr = 8'h91; host_wdata = 8'h51;
    tick; host_addr = 8'h92; host_wdata = 8'h52;
    RESET = 1;
    #1;
    checks++; if (host_ack !== 1'b0 || mem_mw !== 1'b0) $display("FAIL rmb_ack/mw got %b%b want 00", host_ack, mem_mw); else passes++;
    tick;
    RESET = 0; host_req = 0;
    #1;
    checks++; if (mem[8'h92] !== 8'hEE) $display("FAIL rmb_uncommitted got %h want ee", mem[8'h92]); else passes++;
    checks++; if (mem[8'h91] !== 8'h51) $display("FAIL rmb_second got %h want 51", mem[8'h91]); else passes++;
    checks++; if (host_grant !== 1'b0 || cpu_en_l !== 1'b0) $display("FAIL rmb_cpu_state grant/en_l got %b%b want 00", host_grant, cpu_en_l); else passes++;
  endtask

  task automatic test_ext_disable;
    ext_en_l = 1; cpu_mw = 1; cpu_addr = 8'h30; cpu_data = 8'h99;
    #1;
    checks++; if (mem_mw !== 1'b0) $display("FAIL ext_mw got %b want 0", mem_mw); else passes++;
    checks++; if (cpu_en_l !== 1'b1) $display("FAIL ext_en_l got %b want 1", cpu_en_l); else passes++;
    host_req = 1; host_we = 0; host_addr = 8'h20;
    tick;
    checks++; if (mem[8'h30] === 8'h99) $display("FAIL ext_no_commit got %h want not 99", mem[8'h30]); else passes++;
    checks++; if (host_ack !== 1'b1 || host_grant !== 1'b1) $display("FAIL ext_host_grant ack/grant got %b%b want 11", host_ack, host_grant); else passes++;
    checks++; if (host_rdata !== 8'hA5) $display("FAIL ext_host_rdata got %h want a5", host_rdata); else passes++;
    tick;
    host_req = 0;
    tick;
    ext_en_l = 0; cpu_mw = 0;
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_read;
    test_burst;
    test_reset_mid_burst;
    test_ext_disable;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Shares the single data-memory port (`lab3dram`) between the CPU's load/store path and an external host port. The host port serves debug, test-bench preload and DMA-style access. The arbiter sits between `cpu` and `lab3dram` in `main`: it muxes the address, write-data and write-enable lines, and it stalls the CPU through its active-low enable while the host owns the port. Ownership is a small registered FSM with a bounded host burst, so the CPU is never starved.

## Interface

- `ADDR_W`, 8, address width (matches `DataD`)
- `DATA_W`, 8, data width (matches `DataB`/`Din`)
- `MAX_BURST`, 4, max consecutive host transfers before one CPU slot is forced (1..255)

- `CLK`  in  1  single clock, all state updates on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `ext_en_l`  in  1  board-level CPU enable, active low
- `cpu_addr`  in  ADDR_W  CPU data address (`DataD`)
- `cpu_data`  in  DATA_W  CPU store data (`DataB`)
- `cpu_mw`  in  1  CPU memory write
- `cpu_din`  out  DATA_W  load data to CPU (`Din`)
- `cpu_en_l`  out  1  CPU enable to `cpu.EN_L`, active low; 1 = stalled
- `host_req`  in  1  host transfer request
- `host_we`  in  1  host write (1) / read (0)
- `host_addr`  in  ADDR_W  host address
- `host_wdata`  in  DATA_W  host write data
- `host_ack`  out  1  transfer completes at the next rising edge
- `host_rdata`  out  DATA_W  host read data, valid while `host_ack`=1
- `host_grant`  out  1  host owns the memory port (state HOST)
- `mem_addr`  out  ADDR_W  to `lab3dram.ADDR`
- `mem_data`  out  DATA_W  to `lab3dram.DATA`
- `mem_mw`  out  1  to `lab3dram.MW`
- `mem_q`  in  DATA_W  from `lab3dram.Q` (combinational read)

## Operation

- States: CPU (default), HOST, YIELD. Burst counter `bcnt` is `ceil(log2(MAX_BURST+1))` bits wide, saturating, cleared whenever the state is not HOST.
- `cpu_din` = `mem_q` and `host_rdata` = `mem_q` at all times.
- **CPU state.**
  - Mux drives `cpu_addr`, `cpu_data` and `cpu_mw & ~ext_en_l`.
  - `cpu_en_l` = `ext_en_l`; `host_ack` = 0; `host_grant` = 0.
  - If `host_req` = 1, next state is HOST.
- **HOST state.**
  - Mux drives `host_addr`, `host_wdata` and `host_we & host_req`.
  - `cpu_en_l` = 1; `host_grant` = 1; `host_ack` = `host_req`.
  - Each acked cycle increments `bcnt`.
  - Next state:
    - `host_req` = 0 → CPU.
    - Acked cycle with `bcnt` = `MAX_BURST`-1 → YIELD.
    - Otherwise stay in HOST.
- **YIELD state.**
  - Outputs are identical to the CPU state, so the CPU gets exactly one cycle.
  - Next state is HOST if `host_req` = 1, else CPU.
- **Host handshake.**
  - Hold `req`, `we`, `addr` and `wdata` stable until `host_ack` is seen high.
  - Each cycle with `host_ack` = 1 is one completed transfer. Present the next transfer's fields in the same cycle, or drop `req`.
  - Read data is sampled during the ack cycle.
- CPU-side `cpu_mw` is ignored in HOST; the CPU is stalled, so it re-presents the access later.
- While `RESET` = 1:
  - `mem_mw` = 0, `host_ack` = 0, `host_grant` = 0, `cpu_en_l` = 1.
  - Mux selects the CPU side.
  - Next state is CPU with `bcnt` = 0.
- Reset mid-burst: the transfer in the reset cycle is not committed and not acked. The host must retry after reset.

## Timing

- `host_req` rising at cycle k → HOST at edge k+1 → first `host_ack` in cycle k+1 → write commits at edge k+2. Request-to-ack latency is 1 cycle.
- A burst of N acks with `MAX_BURST`=M takes N + floor((N-1)/M) cycles once started.
- `host_req` dropping while in HOST: the CPU resumes (`cpu_en_l` = `ext_en_l`) in the next cycle.
- `host_ack` and `cpu_en_l` are combinational from the state register and `host_req`/`ext_en_l`. There is no path from `mem_q` to control.

## Configuration

- `DRAM_ARB_FAIRNESS_EN` defined: the YIELD slot and `MAX_BURST` limit apply as described.
- `DRAM_ARB_FAIRNESS_EN` undefined:
  - YIELD is never entered and `bcnt` is not built.
  - The host holds the port for as long as `host_req` = 1.
  - `MAX_BURST` is ignored.

## Test plan

- **Reset:** `RESET`=1 for 2 cycles with `host_req`=1 and `cpu_mw`=1 → `mem_mw`=0, `host_ack`=0, `cpu_en_l`=1. After release → CPU state, `host_ack` rises one cycle later.
- **Single write:** `host_req`=1, `we`=1, `addr`=0x20, `wdata`=0xA5 → cycle after req: `host_ack`=1, `mem_addr`=0x20, `mem_mw`=1, `cpu_en_l`=1. Memory[0x20]=0xA5. Drop req → next cycle `cpu_en_l`=`ext_en_l`, `host_grant`=0.
- **Read:** memory[0x21]=0x3C, host read 0x21 → `host_rdata`=0x3C in the ack cycle, `mem_mw`=0.
- **Burst fairness:** `MAX_BURST`=4 with the macro defined, 10 host writes pending, CPU storing 0x77 to 0x40 → ack pattern 4-gap-4-gap-2. The CPU store commits in the first gap. Without the macro: 10 consecutive acks, CPU stalled throughout.
- **Reset mid-burst:** assert `RESET` in the 3rd ack cycle → that address is unchanged, `host_ack`=0, CPU state after reset.
- **External disable:** `ext_en_l`=1 with `cpu_mw`=1 in CPU state → `mem_mw`=0. A host request is still granted.
